// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcode/func/ALU encodings and tracking-entry type for the pipeline control unit
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // Register fields of the 32-bit instruction word are always 5 bits wide
    localparam int TRK_AW = 5;

    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic              m2reg;
        logic [TRK_AW-1:0] dest;
    } trk_entry_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational decode of one instruction into controls, destination and source-use flags
module instr_decode
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int ALUC_W = 4
) (
    input  logic [31:0]       instr,
    output logic              branch,
    output logic              wreg,
    output logic              m2reg,
    output logic              wmem,
    output logic              shift,
    output logic              aluimm,
    output logic              sext,
    output logic              regrt,
    output logic [ALUC_W-1:0] aluc,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] dest,
    output logic              use_rs,
    output logic              use_rt
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] alu;
    logic       fn_known;
    logic       unused_shamt;

    assign op           = instr[31:26];
    assign fn           = instr[5:0];
    assign rs           = REG_AW'(instr[25:21]);
    assign rt           = REG_AW'(instr[20:16]);
    assign aluc         = ALUC_W'(alu);
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        branch   = 1'b0;
        wreg     = 1'b0;
        m2reg    = 1'b0;
        wmem     = 1'b0;
        shift    = 1'b0;
        aluimm   = 1'b0;
        sext     = 1'b0;
        regrt    = 1'b0;
        alu      = ALU_ADD;
        dest     = '0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        fn_known = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  alu = ALU_ADD;
                    FN_SUB:  alu = ALU_SUB;
                    FN_AND:  alu = ALU_AND;
                    FN_OR:   alu = ALU_OR;
                    FN_NOR:  alu = ALU_NOR;
                    FN_SLT:  alu = ALU_SLT;
                    FN_SLL:  alu = ALU_SLL;
                    FN_SRL:  alu = ALU_SRL;
                    FN_SRA:  alu = ALU_SRA;
                    default: fn_known = 1'b0;
                endcase
                // An unknown func decodes as a complete no-op, including source use
                if (fn_known) begin
                    wreg   = 1'b1;
                    shift  = (fn[5:2] == 4'b0000);
                    use_rs = (fn[5:2] != 4'b0000);
                    use_rt = 1'b1;
                    dest   = REG_AW'(instr[15:11]);
                end
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
                aluimm = 1'b1;
                sext   = 1'b1;
                regrt  = 1'b1;
                wreg   = 1'b1;
                m2reg  = (op == OP_LW);
                use_rs = 1'b1;
                dest   = rt;
                if (op == OP_ANDI) alu = ALU_AND;
                if (op == OP_ORI)  alu = ALU_OR;
            end
            OP_SW: begin
                aluimm = 1'b1;
                sext   = 1'b1;
                regrt  = 1'b1;
                wmem   = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu    = ALU_SUB;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - ID decode, in-flight dest tracking, hazard stall/flush and forwarding; PIPE_CTRL_FORWARD_EN enables forwarding
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       id_instr,
    input  logic              id_valid,
    input  logic              branch_taken,
    output logic              cu_branch,
    output logic              cu_wreg,
    output logic              cu_m2reg,
    output logic              cu_wmem,
    output logic              cu_shift,
    output logic              cu_aluimm,
    output logic              cu_sext,
    output logic              cu_regrt,
    output logic [ALUC_W-1:0] cu_aluc,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int FWD_N = (STAGES < 3) ? STAGES : 3;
`ifdef PIPE_CTRL_FORWARD_EN
    localparam int HIT_N = FWD_N;
`else
    localparam int HIT_N = STAGES - 1;
`endif

    logic              dec_branch;
    logic              dec_wreg;
    logic              dec_wmem;
    logic [REG_AW-1:0] dec_rs;
    logic [REG_AW-1:0] dec_rt;
    logic [REG_AW-1:0] dec_dest;
    logic              dec_use_rs;
    logic              dec_use_rt;
    logic              kill;
    logic              stall_raw;
    logic [1:0]        fwd_a_c;
    logic [1:0]        fwd_b_c;
    logic [HIT_N-1:0]  hit_rs;
    logic [HIT_N-1:0]  hit_rt;
    logic              unused_trk;

    trk_entry_t trk [STAGES];

    instr_decode #(
        .REG_AW (REG_AW),
        .ALUC_W (ALUC_W)
    ) u_dec (
        .instr  (id_instr),
        .branch (dec_branch),
        .wreg   (dec_wreg),
        .m2reg  (cu_m2reg),
        .wmem   (dec_wmem),
        .shift  (cu_shift),
        .aluimm (cu_aluimm),
        .sext   (cu_sext),
        .regrt  (cu_regrt),
        .aluc   (cu_aluc),
        .rs     (dec_rs),
        .rt     (dec_rt),
        .dest   (dec_dest),
        .use_rs (dec_use_rs),
        .use_rt (dec_use_rt)
    );

    // Register 0 is hard-wired, so a zero source can never depend on anything
    always_comb begin
        hit_rs = '0;
        hit_rt = '0;
        for (int i = 0; i < HIT_N; i++) begin
            hit_rs[i] = dec_use_rs && (dec_rs != '0) && trk[i].valid && trk[i].wreg &&
                        (trk[i].dest == TRK_AW'(dec_rs));
            hit_rt[i] = dec_use_rt && (dec_rt != '0) && trk[i].valid && trk[i].wreg &&
                        (trk[i].dest == TRK_AW'(dec_rt));
        end
    end

`ifdef PIPE_CTRL_FORWARD_EN
    always_comb begin
        stall_raw = (hit_rs[0] | hit_rt[0]) & trk[0].m2reg;
        fwd_a_c   = FWD_RF;
        fwd_b_c   = FWD_RF;
        // Walk oldest to youngest so the youngest producer overrides
        for (int i = HIT_N - 1; i >= 0; i--) begin
            if (hit_rs[i]) fwd_a_c = 2'(i + 1);
            if (hit_rt[i]) fwd_b_c = 2'(i + 1);
        end
    end
    assign unused_trk = ^{trk[STAGES-1]};
`else
    // The last tracked stage writes the regfile through, so it never stalls
    always_comb begin
        stall_raw = |(hit_rs | hit_rt);
        fwd_a_c   = FWD_RF;
        fwd_b_c   = FWD_RF;
    end
    assign unused_trk = ^{trk[STAGES-1], trk[0].m2reg};
`endif

    assign flush = branch_taken;
    assign stall = stall_raw & ~branch_taken & rst;
    assign fwd_a = rst ? fwd_a_c : FWD_RF;
    assign fwd_b = rst ? fwd_b_c : FWD_RF;

    assign kill      = ~id_valid | stall | flush;
    assign cu_wreg   = dec_wreg & ~kill;
    assign cu_wmem   = dec_wmem & ~kill;
    assign cu_branch = dec_branch & ~kill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                trk[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            trk[0] <= '{valid: ~kill, wreg: dec_wreg, m2reg: cu_m2reg, dest: TRK_AW'(dec_dest)};
            for (int i = 1; i < STAGES; i++) begin
                trk[i] <= trk[i-1];
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - randomized and directed self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;
    import ctrl_pkg::*;

    localparam int STAGES = 3;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       id_instr;
    logic              id_valid;
    logic              branch_taken;
    logic              cu_branch, cu_wreg, cu_m2reg, cu_wmem;
    logic              cu_shift, cu_aluimm, cu_sext, cu_regrt;
    logic [3:0]        cu_aluc;
    logic              stall, flush;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.STAGES(STAGES), .REG_AW(5), .ALUC_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
        .branch_taken(branch_taken), .cu_branch(cu_branch), .cu_wreg(cu_wreg),
        .cu_m2reg(cu_m2reg), .cu_wmem(cu_wmem), .cu_shift(cu_shift),
        .cu_aluimm(cu_aluimm), .cu_sext(cu_sext), .cu_regrt(cu_regrt),
        .cu_aluc(cu_aluc), .stall(stall), .flush(flush), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    typedef enum int {
        K_ADD, K_SUB, K_AND, K_OR, K_NOR, K_SLT, K_SLL, K_SRL, K_SRA,
        K_ADDI, K_ANDI, K_ORI, K_LW, K_SW, K_BEQ, K_BADOP, K_BADFN
    } kind_e;

    // flags = {branch, wreg, m2reg, wmem, shift, aluimm, sext, regrt}; dsel 0 none, 1 rd, 2 rt
    typedef struct {
        logic [7:0] flags;
        logic [3:0] alu;
        bit         urs;
        bit         urt;
        int         dsel;
    } ispec_t;

    typedef struct {
        bit v;
        bit w;
        bit m;
        int dest;
    } inflight_t;

    int        n_checks = 0;
    int        n_errors = 0;
    int        cyc = 0;
    int        m_cnt = 0;
    inflight_t hist[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] encode(input kind_e k, input int rs, input int rt, input int rd);
        logic [4:0]  s, t, d;
        logic [15:0] imm;
        s = 5'(rs); t = 5'(rt); d = 5'(rd); imm = 16'h0f0c;
        case (k)
            K_ADD:   return {6'h00, s, t, d, 5'd3, 6'h20};
            K_SUB:   return {6'h00, s, t, d, 5'd3, 6'h22};
            K_AND:   return {6'h00, s, t, d, 5'd3, 6'h24};
            K_OR:    return {6'h00, s, t, d, 5'd3, 6'h25};
            K_NOR:   return {6'h00, s, t, d, 5'd3, 6'h27};
            K_SLT:   return {6'h00, s, t, d, 5'd3, 6'h2a};
            K_SLL:   return {6'h00, s, t, d, 5'd3, 6'h00};
            K_SRL:   return {6'h00, s, t, d, 5'd3, 6'h02};
            K_SRA:   return {6'h00, s, t, d, 5'd3, 6'h03};
            K_ADDI:  return {6'h08, s, t, imm};
            K_ANDI:  return {6'h0c, s, t, imm};
            K_ORI:   return {6'h0d, s, t, imm};
            K_LW:    return {6'h23, s, t, imm};
            K_SW:    return {6'h2b, s, t, imm};
            K_BEQ:   return {6'h04, s, t, imm};
            K_BADOP: return {6'h3f, s, t, imm};
            default: return {6'h00, s, t, d, 5'd3, 6'h3f};
        endcase
    endfunction

    function automatic ispec_t spec_of(input kind_e k);
        ispec_t e;
        e = '{flags: 8'b0, alu: ALU_ADD, urs: 0, urt: 0, dsel: 0};
        case (k)
            K_ADD:  e = '{8'b0100_0000, ALU_ADD, 1, 1, 1};
            K_SUB:  e = '{8'b0100_0000, ALU_SUB, 1, 1, 1};
            K_AND:  e = '{8'b0100_0000, ALU_AND, 1, 1, 1};
            K_OR:   e = '{8'b0100_0000, ALU_OR,  1, 1, 1};
            K_NOR:  e = '{8'b0100_0000, ALU_NOR, 1, 1, 1};
            K_SLT:  e = '{8'b0100_0000, ALU_SLT, 1, 1, 1};
            K_SLL:  e = '{8'b0100_1000, ALU_SLL, 0, 1, 1};
            K_SRL:  e = '{8'b0100_1000, ALU_SRL, 0, 1, 1};
            K_SRA:  e = '{8'b0100_1000, ALU_SRA, 0, 1, 1};
            K_ADDI: e = '{8'b0100_0111, ALU_ADD, 1, 0, 2};
            K_ANDI: e = '{8'b0100_0111, ALU_AND, 1, 0, 2};
            K_ORI:  e = '{8'b0100_0111, ALU_OR,  1, 0, 2};
            K_LW:   e = '{8'b0110_0111, ALU_ADD, 1, 0, 2};
            K_SW:   e = '{8'b0001_0111, ALU_ADD, 1, 1, 0};
            K_BEQ:  e = '{8'b1000_0000, ALU_SUB, 1, 1, 0};
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit produces(input inflight_t h, input int src);
        return (src != 0) && h.v && h.w && (h.dest == src);
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < STAGES; i++) hist.push_back('{v: 0, w: 0, m: 0, dest: 0});
        m_cnt = 0;
    endtask

    // One pipeline cycle: drive ID, compare combinational outputs, then advance the model
    task automatic step(input kind_e k, input int rs, input int rt, input int rd,
                        input bit v, input bit br);
        ispec_t     e;
        int         dst, fa, fb;
        bit         st;
        logic [7:0] fl;
        @(negedge clk);
        id_instr = encode(k, rs, rt, rd);
        id_valid = v;
        branch_taken = br;
        #1;
        cyc++;
        e   = spec_of(k);
        dst = (e.dsel == 1) ? rd : (e.dsel == 2) ? rt : 0;
        st = 0; fa = 0; fb = 0;
`ifdef PIPE_CTRL_FORWARD_EN
        st = ((e.urs && produces(hist[0], rs)) || (e.urt && produces(hist[0], rt))) && hist[0].m;
        for (int i = 0; i < STAGES && i < 3; i++) begin
            if (fa == 0 && e.urs && produces(hist[i], rs)) fa = i + 1;
            if (fb == 0 && e.urt && produces(hist[i], rt)) fb = i + 1;
        end
`else
        for (int i = 0; i <= STAGES - 2; i++) begin
            if ((e.urs && produces(hist[i], rs)) || (e.urt && produces(hist[i], rt))) st = 1;
        end
`endif
        if (br) st = 0;
        fl = e.flags;
        if (!v || st || br) fl = fl & 8'b0110_1111 & 8'b1011_1111 & 8'b0111_1111;
        check_eq($sformatf("stall@%0d", cyc), stall, st);
        check_eq($sformatf("flush@%0d", cyc), flush, br);
        check_eq($sformatf("fwd_a@%0d", cyc), fwd_a, fa);
        check_eq($sformatf("fwd_b@%0d", cyc), fwd_b, fb);
        check_eq($sformatf("ctrl@%0d", cyc),
                 {cu_branch, cu_wreg, cu_m2reg, cu_wmem, cu_shift, cu_aluimm, cu_sext, cu_regrt, cu_aluc},
                 {fl, e.alu});
        check_eq($sformatf("stall_cnt@%0d", cyc), stall_cnt, m_cnt);
        if (st && m_cnt < CNT_MAX) m_cnt++;
        hist.push_front('{v: v && !st && !br, w: e.flags[6], m: e.flags[5], dest: dst});
        void'(hist.pop_back());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(K_BADOP, 0, 0, 0, 0, 0);
    endtask

    initial begin
        kind_e rk;
        rst = 1'b0;
        id_instr = '0;
        id_valid = 1'b0;
        branch_taken = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        id_instr = encode(K_LW, 1, 2, 0);
        id_valid = 1'b1;
        #1;
        check_eq("rst_stall", stall, 0);
        check_eq("rst_cnt", stall_cnt, 0);
        check_eq("rst_fwd", {fwd_a, fwd_b}, 0);
        check_eq("rst_decode", {cu_wreg, cu_m2reg, cu_aluimm, cu_regrt}, 4'b1111);
        @(negedge clk);
        rst = 1'b1;
        id_valid = 1'b0;

        // load-use
        step(K_LW, 1, 2, 0, 1, 0);
        step(K_ADD, 2, 4, 3, 1, 0);
        check_eq("lu_stall", stall, 1);
`ifdef PIPE_CTRL_FORWARD_EN
        step(K_ADD, 2, 4, 3, 1, 0);
        check_eq("lu_after_stall", stall, 0);
        check_eq("lu_fwd_a", fwd_a, 2);
        check_eq("lu_cnt", stall_cnt, 1);
`else
        step(K_ADD, 2, 4, 3, 1, 0);
        check_eq("lu_stall2", stall, 1);
        step(K_ADD, 2, 4, 3, 1, 0);
        check_eq("lu_after_stall", stall, 0);
        check_eq("lu_cnt", stall_cnt, 2);
`endif

        // ALU RAW
        idle(3);
        step(K_ADD, 1, 1, 2, 1, 0);
        step(K_SUB, 2, 2, 5, 1, 0);
`ifdef PIPE_CTRL_FORWARD_EN
        check_eq("raw_fwd", {fwd_a, fwd_b}, 4'b0101);
        check_eq("raw_stall", stall, 0);
`else
        check_eq("raw_stall1", stall, 1);
        step(K_SUB, 2, 2, 5, 1, 0);
        check_eq("raw_stall2", stall, 1);
        step(K_SUB, 2, 2, 5, 1, 0);
        check_eq("raw_stall_end", stall, 0);
`endif

        // register 0 never creates a dependency
        idle(3);
        step(K_ADD, 1, 1, 0, 1, 0);
        step(K_ADD, 0, 0, 3, 1, 0);
        check_eq("r0_stall", stall, 0);
        check_eq("r0_fwd", {fwd_a, fwd_b}, 0);

        // flush beats a pending load-use
        idle(3);
        step(K_LW, 1, 2, 0, 1, 0);
        step(K_ADD, 2, 4, 3, 1, 1);
        check_eq("fl_flush", flush, 1);
        check_eq("fl_stall", stall, 0);
        check_eq("fl_wreg", cu_wreg, 0);
        step(K_OR, 3, 3, 7, 1, 0);
        check_eq("fl_bubble_stall", stall, 0);
        check_eq("fl_bubble_fwd", fwd_a, 0);

        // unknown func decodes to all-zero controls
        idle(3);
        step(K_BADFN, 1, 2, 3, 1, 0);
        check_eq("badfn_ctrl", {cu_wreg, cu_shift, cu_aluimm, cu_aluc}, {3'b000, ALU_ADD});

        // counter saturation
        for (int i = 0; i < 20; i++) begin
            step(K_LW, 1, 2, 0, 1, 0);
            step(K_ADD, 2, 4, 3, 1, 0);
        end
        idle(1);
        check_eq("cnt_sat", stall_cnt, CNT_MAX);

        // reset in the middle of a stall
        idle(3);
        step(K_LW, 1, 2, 0, 1, 0);
        step(K_ADD, 2, 4, 3, 1, 0);
        check_eq("mr_pre_stall", stall, 1);
        rst = 1'b0;
        #1;
        check_eq("mr_stall", stall, 0);
        check_eq("mr_cnt", stall_cnt, 0);
        check_eq("mr_fwd", {fwd_a, fwd_b}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        id_valid = 1'b0;
        branch_taken = 1'b0;
        step(K_ADD, 2, 4, 3, 1, 0);
        check_eq("mr_post_stall", stall, 0);

        // randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 600; n++) begin
            rk = kind_e'($urandom_range(0, 15));
            step(rk, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
